// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared encodings and helpers for the traffic-light safety monitor
package tl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_NS_ONEHOT = 3'd1;
  localparam logic [2:0] FC_WE_ONEHOT = 3'd2;
  localparam logic [2:0] FC_CONFLICT  = 3'd3;
  localparam logic [2:0] FC_NS_TRANS  = 3'd4;
  localparam logic [2:0] FC_WE_TRANS  = 3'd5;
  localparam logic [2:0] FC_SHORT_YEL = 3'd6;

  function automatic logic is_onehot(input logic [2:0] lamp);
    return (lamp == LAMP_R) || (lamp == LAMP_Y) || (lamp == LAMP_G);
  endfunction

  // Only the three "skip a colour" moves are illegal; holding a colour is always fine.
  function automatic logic is_illegal_step(input logic [2:0] prev, input logic [2:0] nxt);
    return ((prev == LAMP_G) && (nxt == LAMP_R)) ||
           ((prev == LAMP_Y) && (nxt == LAMP_G)) ||
           ((prev == LAMP_R) && (nxt == LAMP_Y));
  endfunction

endpackage

// File: rtl/tl_dir_checker.sv
// rtl/tl_dir_checker.sv - per-direction lamp history, yellow counter and rule checks
module tl_dir_checker
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [2:0] lamp_i,
  input  logic       update_i,
  output logic       onehot_err,
  output logic       trans_err,
  output logic       short_yel_err,
  output logic       non_red
);

  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] yel_cnt_q, yel_cnt_d;

  // Track the last sampled lamp and how long yellow has been held (saturating).
  always_comb begin
    prev_d    = prev_q;
    yel_cnt_d = yel_cnt_q;
    if (update_i) begin
      prev_d = lamp_i;
      if (lamp_i == LAMP_Y) begin
        if (yel_cnt_q < CNT_W'(MIN_YELLOW)) begin
          yel_cnt_d = yel_cnt_q + 1'b1;
        end
      end else begin
        yel_cnt_d = '0;
      end
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      prev_q    <= LAMP_R;
      yel_cnt_q <= '0;
    end else begin
      prev_q    <= prev_d;
      yel_cnt_q <= yel_cnt_d;
    end
  end

  assign onehot_err    = !is_onehot(lamp_i);
  assign trans_err     = is_illegal_step(prev_q, lamp_i);
  assign short_yel_err = (prev_q == LAMP_Y) && (lamp_i == LAMP_R) &&
                         (yel_cnt_q < CNT_W'(MIN_YELLOW));
  assign non_red       = lamp_i[1] | lamp_i[0];

endmodule

// File: rtl/tl_safety_monitor.sv
// rtl/tl_safety_monitor.sv - lamp pass-through guard with fault latch and fail-safe red flash
module tl_safety_monitor
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 50,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       RED_NS,
  input  logic       YELLOW_NS,
  input  logic       GREEN_NS,
  input  logic       RED_WE,
  input  logic       YELLOW_WE,
  input  logic       GREEN_WE,
  input  logic       fault_ack,
  output logic [2:0] LAMP_NS,
  output logic [2:0] LAMP_WE,
  output logic       fault,
  output logic [2:0] fault_code
);

  logic [2:0] in_ns, in_we;
  assign in_ns = {RED_NS, YELLOW_NS, GREEN_NS};
  assign in_we = {RED_WE, YELLOW_WE, GREEN_WE};

  state_e           state_q, state_d;
  logic [2:0]       lamp_ns_q, lamp_ns_d;
  logic [2:0]       lamp_we_q, lamp_we_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             flash_q, flash_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;

  logic ns_onehot_err, ns_trans_err, ns_short_err, ns_non_red;
  logic we_onehot_err, we_trans_err, we_short_err, we_non_red;
  logic update_hist, checks_en;
  logic [2:0] viol_code;

  // History advances whenever the lamps are being passed through (IDLE and MONITOR).
  assign update_hist = (state_q != ST_FAULT);
  assign checks_en   = (state_q == ST_MONITOR);

  tl_dir_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_ns_chk (
    .clk           (clk),
    .clear_n       (clear_n),
    .lamp_i        (in_ns),
    .update_i      (update_hist),
    .onehot_err    (ns_onehot_err),
    .trans_err     (ns_trans_err),
    .short_yel_err (ns_short_err),
    .non_red       (ns_non_red)
  );

  tl_dir_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_we_chk (
    .clk           (clk),
    .clear_n       (clear_n),
    .lamp_i        (in_we),
    .update_i      (update_hist),
    .onehot_err    (we_onehot_err),
    .trans_err     (we_trans_err),
    .short_yel_err (we_short_err),
    .non_red       (we_non_red)
  );

  // Priority encoder: lowest code wins; history-based checks only count in MONITOR.
  always_comb begin
    viol_code = FC_NONE;
    if (ns_onehot_err) begin
      viol_code = FC_NS_ONEHOT;
    end else if (we_onehot_err) begin
      viol_code = FC_WE_ONEHOT;
    end else if (ns_non_red && we_non_red) begin
      viol_code = FC_CONFLICT;
    end else if (checks_en && ns_trans_err) begin
      viol_code = FC_NS_TRANS;
    end else if (checks_en && we_trans_err) begin
      viol_code = FC_WE_TRANS;
    end else if (checks_en && (ns_short_err || we_short_err)) begin
      viol_code = FC_SHORT_YEL;
    end
  end

  // Next-state and output selection for the IDLE/MONITOR/FAULT machine.
  always_comb begin
    state_d     = state_q;
    lamp_ns_d   = lamp_ns_q;
    lamp_we_d   = lamp_we_q;
    fault_d     = fault_q;
    code_d      = code_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    case (state_q)
      ST_IDLE, ST_MONITOR: begin
        if (viol_code != FC_NONE) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = viol_code;
          flash_d     = 1'b1;
          flash_cnt_d = '0;
          lamp_ns_d   = LAMP_R;
          lamp_we_d   = LAMP_R;
        end else begin
          state_d   = ST_MONITOR;
          lamp_ns_d = in_ns;
          lamp_we_d = in_we;
        end
      end
      ST_FAULT: begin
        if (fault_ack && (in_ns == LAMP_R) && (in_we == LAMP_R)) begin
          state_d     = ST_IDLE;
          fault_d     = 1'b0;
          code_d      = FC_NONE;
          flash_d     = 1'b1;
          flash_cnt_d = '0;
          lamp_ns_d   = LAMP_R;
          lamp_we_d   = LAMP_R;
        end else begin
          if (flash_cnt_q == CNT_W'(FLASH_HALF - 1)) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          lamp_ns_d = {flash_d, 2'b00};
          lamp_we_d = {flash_d, 2'b00};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      lamp_ns_q   <= LAMP_R;
      lamp_we_q   <= LAMP_R;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lamp_ns_q   <= lamp_ns_d;
      lamp_we_q   <= lamp_we_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign LAMP_NS    = lamp_ns_q;
  assign LAMP_WE    = lamp_we_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_tl_safety_monitor.sv
// tb/tb_tl_safety_monitor.sv - self-checking bench with behavioural model for tl_safety_monitor
module tb_tl_safety_monitor;

  localparam int FH = 4;
  localparam int MIN_Y = 3;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [2:0] ns_in = 3'b100;
  logic [2:0] we_in = 3'b100;
  logic       fault_ack = 1'b0;
  logic [2:0] lamp_ns, lamp_we, fault_code;
  logic       fault;

  int tests = 0;
  int fails = 0;

  tl_safety_monitor #(.MIN_YELLOW(3), .FLASH_HALF(4), .CNT_W(8)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .RED_NS     (ns_in[2]),
    .YELLOW_NS  (ns_in[1]),
    .GREEN_NS   (ns_in[0]),
    .RED_WE     (we_in[2]),
    .YELLOW_WE  (we_in[1]),
    .GREEN_WE   (we_in[0]),
    .fault_ack  (fault_ack),
    .LAMP_NS    (lamp_ns),
    .LAMP_WE    (lamp_we),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = monitoring, 2 = fault.
  int         m_mode, m_age, m_run_ns, m_run_we, m_c;
  logic [2:0] m_ns, m_we, m_code, m_prev_ns, m_prev_we;
  logic       m_fault;

  function automatic bit legal_step(input logic [2:0] p, input logic [2:0] n);
    return (p == G && (n == G || n == Y)) ||
           (p == Y && (n == Y || n == R)) ||
           (p == R && (n == R || n == G));
  endfunction

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_mode = 0; m_age = 0; m_run_ns = 0; m_run_we = 0;
      m_ns = R; m_we = R; m_code = 0; m_fault = 0; m_prev_ns = R; m_prev_we = R;
    end else if (m_mode == 2) begin
      if (fault_ack && ns_in == R && we_in == R) begin
        m_mode = 0; m_fault = 0; m_code = 0; m_ns = R; m_we = R;
      end else begin
        m_age++;
        m_ns = {((m_age / FH) % 2 == 0), 2'b00};
        m_we = m_ns;
      end
    end else begin
      m_c = 0;
      if ($countones(ns_in) != 1) m_c = 1;
      else if ($countones(we_in) != 1) m_c = 2;
      else if (ns_in != R && we_in != R) m_c = 3;
      else if (m_mode == 1) begin
        if (!legal_step(m_prev_ns, ns_in)) m_c = 4;
        else if (!legal_step(m_prev_we, we_in)) m_c = 5;
        else if ((m_prev_ns == Y && ns_in == R && m_run_ns < MIN_Y) ||
                 (m_prev_we == Y && we_in == R && m_run_we < MIN_Y)) m_c = 6;
      end
      if (m_c != 0) begin
        m_mode = 2; m_fault = 1; m_code = 3'(m_c); m_age = 0; m_ns = R; m_we = R;
      end else begin
        m_mode = 1; m_ns = ns_in; m_we = we_in;
      end
      m_run_ns = (ns_in == Y) ? m_run_ns + 1 : 0;
      m_run_we = (we_in == Y) ? m_run_we + 1 : 0;
      m_prev_ns = ns_in;
      m_prev_we = we_in;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (clear_n) begin
      check("lamp_ns", lamp_ns, m_ns);
      check("lamp_we", lamp_we, m_we);
      check("fault", {2'b00, fault}, {2'b00, m_fault});
      check("fault_code", fault_code, m_code);
    end
  end

  task automatic cyc(input logic [2:0] ns, input logic [2:0] we, input logic ack);
    ns_in = ns;
    we_in = we;
    fault_ack = ack;
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] ns, input logic [2:0] we, input int n);
    for (int i = 0; i < n; i++) cyc(ns, we, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_lamp_ns", lamp_ns, 3'b100);
    check("rst_lamp_we", lamp_we, 3'b100);
    check("rst_fault", {2'b00, fault}, 3'b000);
    check("rst_code", fault_code, 3'b000);
    clear_n = 1'b1;
    cyc(R, R, 1'b0);

    // Legal sequence, twice.
    for (int p = 0; p < 2; p++) begin
      cyc(G, R, 1'b0);
      if (p == 0) check("pass_lat_ns", lamp_ns, 3'b001);
      run(G, R, 4); run(Y, R, 3); run(R, R, 1);
      run(R, G, 5); run(R, Y, 3); run(R, R, 1);
    end
    check("legal_fault", {2'b00, fault}, 3'b000);

    // Short yellow, then exactly-minimum yellow.
    cyc(G, R, 1'b0); cyc(Y, R, 1'b0); cyc(Y, R, 1'b0); cyc(R, R, 1'b0);
    check("short_yel_code", fault_code, 3'd6);
    check("short_yel_lamp", lamp_ns, 3'b100);
    cyc(R, R, 1'b1);
    check("ack_code", fault_code, 3'd0);
    cyc(R, R, 1'b0);
    cyc(G, R, 1'b0); run(Y, R, 3); cyc(R, R, 1'b0);
    check("min_yel_fault", {2'b00, fault}, 3'b000);
    check("min_yel_lamp", lamp_ns, 3'b100);

    // Conflict and flash timing.
    cyc(G, G, 1'b0);
    check("conflict_code", fault_code, 3'd3);
    check("conflict_lamp", lamp_we, 3'b100);
    run(R, R, 4);
    check("flash_off_ns", lamp_ns, 3'b000);
    check("flash_off_we", lamp_we, 3'b000);
    run(R, R, 4);
    check("flash_on_ns", lamp_ns, 3'b100);
    cyc(R, R, 1'b1); cyc(R, R, 1'b0);

    // WE illegal transition, ack handling, IDLE skips history checks.
    cyc(R, G, 1'b0); cyc(R, R, 1'b0);
    check("we_trans_code", fault_code, 3'd5);
    cyc(G, R, 1'b1);
    check("bad_ack_fault", {2'b00, fault}, 3'b001);
    check("bad_ack_code", fault_code, 3'd5);
    cyc(R, R, 1'b1);
    check("good_ack_fault", {2'b00, fault}, 3'b000);
    check("good_ack_lamp", lamp_ns, 3'b100);
    cyc(Y, R, 1'b0);
    check("idle_no_trans", {2'b00, fault}, 3'b000);
    cyc(R, R, 1'b0);
    check("idle_yel_count", fault_code, 3'd6);
    cyc(R, R, 1'b1); cyc(R, R, 1'b0);

    // Priority and code holding in FAULT.
    cyc(3'b011, G, 1'b0);
    check("prio_code", fault_code, 3'd1);
    cyc(G, G, 1'b0);
    check("hold_code", fault_code, 3'd1);
    cyc(3'b000, R, 1'b0);

    // Asynchronous clear mid-cycle while faulted.
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("async_lamp_ns", lamp_ns, 3'b100);
    check("async_lamp_we", lamp_we, 3'b100);
    check("async_fault", {2'b00, fault}, 3'b000);
    check("async_code", fault_code, 3'b000);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
